// File: rtl/l1_pkg.sv
// Shared definitions for the L1 output RAM: geometry, pooling FSM states
// and the signed max used by the pooling datapath.
package l1_pkg;

    localparam int L1_OUT_DEPTH  = 26;
    localparam int L1_OUT_ADDR_W = 5;
    localparam int L1_MAX_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } pool_state_e;

    // Ties resolve to the even (first) word of the pair.
    function automatic logic signed [L1_MAX_W-1:0] smax(
        input logic signed [L1_MAX_W-1:0] even_w,
        input logic signed [L1_MAX_W-1:0] odd_w
    );
        return (odd_w > even_w) ? odd_w : even_w;
    endfunction

endpackage

// File: rtl/l1_pool_rd_ctrl_if.sv
// Pooled-result stream towards the next layer (valid/ready).
interface l1_pool_rd_ctrl_if #(
    parameter int DATA_W = 16
);

    logic signed [DATA_W-1:0] out_data_o;
    logic                     out_valid_o;
    logic                     out_ready_i;

    modport master (
        output out_data_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i
    );

endinterface

// File: rtl/l1_pool_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; simultaneous push/pop allowed.
module l1_pool_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic signed [DATA_W-1:0] push_data_i,
    input  logic                     pop_i,
    output logic signed [DATA_W-1:0] head_o,
    output logic [1:0]               count_o
);

    logic signed [DATA_W-1:0] mem_q [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;
    logic                     do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/l1_pool_rd_ctrl.sv
// Reads the full L1 output RAM in address order and streams the max of each
// adjacent (even, odd) pair to the next layer.
module l1_pool_rd_ctrl
    import l1_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = L1_OUT_DEPTH,
    parameter int ADDR_W = L1_OUT_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic                     ram_re_o,
    input  logic signed [DATA_W-1:0] ram_rdata_i,
    l1_pool_rd_ctrl_if.master        out_if,
    output logic                     busy_o,
    output logic                     done_o
);

    if ((DEPTH % 2) != 0) begin : g_depth_odd
        $error("l1_pool_rd_ctrl: DEPTH must be even");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_addr_narrow
        $error("l1_pool_rd_ctrl: ADDR_W too small for DEPTH");
    end

    pool_state_e              state_q, state_d;
    logic                     start_q;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     even_rd_q, odd_rd_q;
    logic                     pif_q, pif_d;
    logic signed [DATA_W-1:0] even_q;

    logic                     start_edge, credit_ok, rd_en, done;
    logic                     push, pop;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] fifo_head;
    logic [1:0]               fifo_cnt;

    assign start_edge = start_i && !start_q;
    assign credit_ok  = ({1'b0, fifo_cnt} + {2'b00, pif_q}) < 3'd2;
    assign push       = odd_rd_q;
    assign pop        = out_if.out_valid_o && out_if.out_ready_i;
    assign pair_max   = DATA_W'(smax(L1_MAX_W'(even_q), L1_MAX_W'(ram_rdata_i)));

    // Odd reads bypass credit so both reads of a pair land on consecutive cycles.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                if (addr_q[0] || credit_ok) begin
                    rd_en = 1'b1;
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!pif_q && (fifo_cnt == 2'd0)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pair-in-flight: raised by the even read, dropped when its result is pushed.
    assign pif_d = (pif_q && !push) || (rd_en && !addr_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            addr_q    <= '0;
            even_rd_q <= 1'b0;
            odd_rd_q  <= 1'b0;
            pif_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_i;
            addr_q    <= addr_d;
            even_rd_q <= rd_en && !addr_q[0];
            odd_rd_q  <= rd_en && addr_q[0];
            pif_q     <= pif_d;
        end
    end

    always_ff @(posedge clk) begin
        if (even_rd_q) begin
            even_q <= ram_rdata_i;
        end
    end

    l1_pool_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(pair_max),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_cnt)
    );

    assign out_if.out_valid_o = (fifo_cnt != 2'd0);
    assign out_if.out_data_o  = out_if.out_valid_o ? fifo_head : '0;
    assign ram_re_o           = rd_en;
    assign ram_addr_o         = addr_q;
    assign busy_o             = (state_q != IDLE);
    assign done_o             = done;

endmodule

// File: tb/tb_l1_pool_rd_ctrl.sv
// Bench for l1_pool_rd_ctrl: RAM model, pairwise-max reference and scoreboard.
module tb_l1_pool_rd_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 26;
    localparam int AW    = 5;
    localparam int NOUT  = DEPTH / 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_i = 1'b0;
    logic [AW-1:0]        ram_addr;
    logic                 ram_re;
    logic signed [DW-1:0] ram_rdata = '0;
    logic                 busy;
    logic                 done;

    l1_pool_rd_ctrl_if #(.DATA_W(DW)) out_if ();

    l1_pool_rd_ctrl #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .ram_addr_o (ram_addr),
        .ram_re_o   (ram_re),
        .ram_rdata_i(ram_rdata),
        .out_if     (out_if),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    task automatic check_val(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: each output is the larger of words 2i and 2i+1, even wins ties.
    task automatic build_exp();
        int a, b;
        exp_q.delete();
        for (int i = 0; i < NOUT; i++) begin
            a = mem[2*i];
            b = mem[2*i+1];
            exp_q.push_back((b > a) ? b : a);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = $signed(DW'($urandom));
    endtask

    // rdy_mode: 0 always ready, 1 random ready, 2 ready low in cycles 4..13.
    task automatic run_pass(input int rdy_mode, input bit spur, input bit rst_mid);
        int k = -2, beat = 0, done_cnt = 0, first_k = -1, done_k = -1;
        int reads = 0, stall_reads = 0, prev_data = 0, prev_addr = 0, rst_phase = 0;
        bit prev_stall = 0, prev_even = 0;
        build_exp();
        while (1) begin
            @(posedge clk);
            #1;
            k++;
            if (rst_phase == 1) begin
                rst = 1'b0;
                rst_phase = 2;
            end
            start_i = (k >= 0) && !(spur && k == 5);
            case (rdy_mode)
                0:       out_if.out_ready_i = 1'b1;
                1:       out_if.out_ready_i = ($urandom_range(0, 3) != 0);
                default: out_if.out_ready_i = !(k >= 4 && k <= 13);
            endcase
            if (rst_mid && rst_phase == 0 && beat == 5) begin
                rst = 1'b1;
                rst_phase = 1;
            end
            if (rst_phase != 0) start_i = 1'b0;
            @(negedge clk);
            if (rst_phase == 2) begin
                check_val("rst_addr", int'(ram_addr), 0);
                check_val("rst_re", int'(ram_re), 0);
                check_val("rst_valid", int'(out_if.out_valid_o), 0);
                check_val("rst_data", int'(out_if.out_data_o), 0);
                check_val("rst_busy", int'(busy), 0);
                check_val("rst_done", int'(done), 0);
                break;
            end
            if (rst_phase == 1) continue;
            if (out_if.out_valid_o && first_k < 0) first_k = k;
            if (prev_stall) begin
                check_val("stall_valid", int'(out_if.out_valid_o), 1);
                check_val("stall_data", int'(out_if.out_data_o), prev_data);
            end
            if (prev_even) begin
                check_val("pair_odd_re", int'(ram_re), 1);
                check_val("pair_odd_addr", int'(ram_addr), prev_addr + 1);
            end
            if (out_if.out_valid_o && out_if.out_ready_i) begin
                check_val($sformatf("beat%0d", beat), int'(out_if.out_data_o),
                          (beat < NOUT) ? exp_q[beat] : 32'h7fff_ffff);
                beat++;
            end
            if (ram_re) reads++;
            if (k == 13) stall_reads = reads;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    check_val("beats_at_done", beat, NOUT);
                end
            end
            prev_stall = out_if.out_valid_o && !out_if.out_ready_i;
            prev_data  = out_if.out_data_o;
            prev_even  = ram_re && !ram_addr[0];
            prev_addr  = ram_addr;
            if (done_k >= 0 && k >= done_k + 3) break;
            if (k > 600) begin
                check_val("pass_timeout", k, 600);
                break;
            end
        end
        if (rst_phase != 2) begin
            check_val("beat_count", beat, NOUT);
            check_val("done_count", done_cnt, 1);
            check_val("busy_after", int'(busy), 0);
            check_val("read_count", reads, DEPTH);
            if (rdy_mode == 0) check_val("first_valid_cycle", first_k, 4);
            if (rdy_mode == 2) check_val("stall_reads_le6", int'(stall_reads <= 6), 1);
        end
    endtask

    initial begin
        int saw;
        out_if.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("init_addr", int'(ram_addr), 0);
        check_val("init_re", int'(ram_re), 0);
        check_val("init_valid", int'(out_if.out_valid_o), 0);
        check_val("init_data", int'(out_if.out_data_o), 0);
        check_val("init_busy", int'(busy), 0);
        check_val("init_done", int'(done), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic ramp: outputs 1,3,...,25
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        run_pass(0, 0, 0);

        // start_i stays high: no second pass may begin
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || ram_re) saw = 1;
        end
        check_val("start_held_idle", saw, 0);
        run_pass(0, 0, 0);

        // Signed pairs plus extremes and ties
        fill_random();
        mem[0] = -16'sd5;     mem[1] = 16'sd3;
        mem[2] = 16'sd7;      mem[3] = -16'sd2;
        mem[4] = -16'sd8;     mem[5] = -16'sd1;
        mem[6] = 16'sd4;      mem[7] = 16'sd4;
        mem[8] = -16'sd32768; mem[9] = 16'sd32767;
        mem[10] = 16'sd32767; mem[11] = -16'sd32768;
        mem[12] = -16'sd32768; mem[13] = -16'sd32768;
        run_pass(1, 0, 0);

        fill_random();
        run_pass(2, 0, 0);

        fill_random();
        run_pass(0, 0, 1);
        run_pass(0, 0, 0);

        fill_random();
        run_pass(1, 1, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_pass(1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_pool_rd_ctrl.md
Name: l1_pool_rd_ctrl

Overview:
- Downstream neighbour of the L1 convolution output controller.
- Once the L1 output RAM is full (conv-ready level), this block reads the RAM back in address order and applies 1-D max-pooling over adjacent pairs.
- Pooled results go to the next layer over a valid/ready stream.
- Owns the RAM read port; the conv side owns the write port.

Parameters:
- DATA_W, 16, width of one RAM word and of pooled output; signed two's complement.
- DEPTH, 26, number of RAM entries per frame; must be even (elaboration-time assertion).
- ADDR_W, 5, RAM address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  conv-frame-ready level from the L1 output controller; a rising edge starts a pass.
- ram_addr_o  out  ADDR_W  output RAM read address.
- ram_re_o  out  1  read enable; data appears on ram_rdata_i exactly 1 cycle later.
- ram_rdata_i  in  DATA_W  RAM read data.
- out_data_o  out  DATA_W  pooled value.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  consumer accepts when valid and ready are both high.
- busy_o  out  1  high from pass start until done_o.
- done_o  out  1  single-cycle pulse when the last pooled value is accepted.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - ram_addr_o=0, ram_re_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0.
  - FSM goes to IDLE, FIFO is emptied, the start edge detector register is cleared.
  - Applies at any point mid-pass; no partial result survives.
- Start detect: a registered copy of start_i; a pass starts on start_i=1 while the registered copy is 0, only in IDLE. Edges seen in any other state are ignored.
- FSM states:
  - IDLE -> READ on a start edge.
  - READ: issue reads for addresses 0..DEPTH-1; go to DRAIN after the read of DEPTH-1 is issued.
  - DRAIN: wait until the last pair result has been pushed and the FIFO is empty, then pulse done_o and go to IDLE.
- Read issue:
  - In READ, ram_re_o=1 with ram_addr_o=a when credit is available; the address then increments.
  - Credit rule: (FIFO count + pair-in-flight) < 2.
  - pair-in-flight is 1 from the cycle the even-address read issues until the cycle its pair result is pushed.
  - Stalls are only allowed before an even address; the two reads of a pair are always issued on consecutive cycles.
- Pooling datapath:
  - Hold the even-address word in a register.
  - On the odd-address return, push max(even, odd) into the FIFO using a signed compare; on a tie, push the even word.
- Output FIFO:
  - 2 entries; head drives out_data_o and out_valid_o.
  - A push and a pop in the same cycle are legal; the count is unchanged.
  - Credit prevents overflow.
- Latency, with no backpressure:
  - Start edge sampled at edge 0.
  - ram_re_o for addr 0 in cycle 1, addr 1 in cycle 2.
  - Data for addr 1 returns in cycle 3; the push happens at the end of cycle 3.
  - out_valid_o=1 in cycle 4.
  - Sustained rate is 1 output per 2 cycles; DEPTH=26 gives 13 outputs.
- busy_o is high in READ and DRAIN, and in the done cycle.
- After done_o the block returns to IDLE; the upstream must deassert and reassert start_i to run another pass.
- ram_addr_o holds its last value when ram_re_o=0.

Decomposition:
- Shared package l1_pkg:
  - FSM state enum (IDLE, READ, DRAIN).
  - L1_OUT_DEPTH=26 and L1_OUT_ADDR_W=5, shared with the conv output controller.
  - Signed max function.
- One sub-module: l1_pool_fifo2, a 2-entry synchronous FIFO with count output, parameterised by DATA_W.

Test Plan:
- Basic pass: RAM preloaded with word[i]=i, start_i rises, out_ready_i=1 -> out_data_o sequence 1,3,...,25; 13 beats, first valid at cycle 4, done_o pulses once, busy_o low after.
- Signed compare: pairs (-5,3), (7,-2), (-8,-1), (4,4) -> outputs 3, 7, -1, 4.
- Backpressure: out_ready_i=0 for 10 cycles after the first valid -> at most 4 reads issued past the first pair, no FIFO overflow, out_data_o stable while stalled, full sequence correct after release.
- Start held / restart: start_i held high after done_o -> no second pass; drop for 1 cycle and raise -> second pass with identical output.
- Reset mid-pass: assert rst at output beat 5 -> next cycle all outputs 0 and IDLE; a new start edge yields the full 13-beat sequence from address 0.
- Spurious start: start_i pulses again during READ -> ignored; exactly 13 beats and one done_o.
